// File: rtl/adex_spike_event_encoder_pkg.sv
// Shared types and defaults for the AdEx spike event encoder.
// Build option: define ADEX_EVT_ISI_EN to emit inter-spike intervals.
package adex_evt_pkg;

   localparam int TS_W_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   function automatic int nbytes(input int w);
      return w / 8;
   endfunction

endpackage

// File: rtl/adex_spike_event_encoder_if.sv
// Byte stream towards the off-chip reader (valid/ready).
// Carries one event as NBYTES bytes, MSB first.
interface adex_spike_event_encoder_if;

   logic [7:0] out_data_o;
   logic       out_valid_o;
   logic       out_ready_i;
   logic       out_last_o;

   modport master (
      output out_data_o,
      output out_valid_o,
      output out_last_o,
      input  out_ready_i
   );

   modport slave (
      input  out_data_o,
      input  out_valid_o,
      input  out_last_o,
      output out_ready_i
   );

endinterface

// File: rtl/adex_spike_event_encoder_fifo.sv
// Synchronous event FIFO, no write-to-read bypass.
// A push is refused while full, even with a same-cycle pop.
module adex_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/adex_spike_event_encoder.sv
// Timestamps neuron spikes, queues them and streams them bytewise.
// Build option: ADEX_EVT_ISI_EN selects inter-spike-interval payloads.
module adex_spike_event_encoder
   import adex_evt_pkg::*;
#(
   parameter int TS_W       = TS_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en_i,
   input  logic                        clear_i,
   input  logic                        tick_i,
   input  logic                        spike_i,
   adex_spike_event_encoder_if.master  out,
   output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
   output logic                        overflow_o,
   output logic [TS_W-1:0]             ts_o
);

   localparam int NB = nbytes(TS_W);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   state_t          state, state_nx;
   logic [TS_W-1:0] shift, shift_nx;
   logic [IW-1:0]   idx, idx_nx;
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] evt;
   logic [TS_W-1:0] rdata;
   logic            full, empty, pop;
   logic            tick_en, spike_en;
   logic            last, hs;

   assign tick_en  = tick_i & en_i;
   assign spike_en = spike_i & en_i;
   assign last     = (idx == IW'(NB-1));
   assign hs       = out.out_valid_o & out.out_ready_i;

   adex_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TS_W),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .push  (spike_en),
      .pop   (pop),
      .wdata (evt),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts         <= '0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         ts         <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (tick_en)         ts         <= ts + 1'b1;
         if (spike_en && full) overflow_o <= 1'b1;
      end
   end

`ifdef ADEX_EVT_ISI_EN
   logic [TS_W-1:0] isi;

   // Restart from the tick that coincides with the spike, if any.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi <= '0;
      end else if (clear_i) begin
         isi <= '0;
      end else if (spike_en) begin
         isi <= TS_W'(tick_en);
      end else if (tick_en && !(&isi)) begin
         isi <= isi + 1'b1;
      end
   end

   assign evt = isi;
`else
   assign evt = ts;
`endif

   assign ts_o = ts;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         shift <= '0;
         idx   <= '0;
      end else if (clear_i) begin
         state <= IDLE;
         shift <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         shift <= shift_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shift_nx = shift;
      idx_nx   = idx;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shift_nx = rdata;
               idx_nx   = '0;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (hs && !last) begin
               shift_nx = shift << 8;
               idx_nx   = idx + 1'b1;
            end else if (hs && !empty) begin
               pop      = 1'b1;
               shift_nx = rdata;
               idx_nx   = '0;
            end else if (hs) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign out.out_valid_o = (state == SEND);
   assign out.out_data_o  = shift[TS_W-1 -: 8];
   assign out.out_last_o  = (state == SEND) & last;

endmodule

// File: tb/tb_adex_spike_event_encoder.sv
// Randomised and directed bench for adex_spike_event_encoder.
// Honours ADEX_EVT_ISI_EN when the design is built with it.
module tb_adex_spike_event_encoder;

   localparam int TS_W  = 16;
   localparam int DEPTH = 8;
   localparam int NB    = TS_W / 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, clr, tick, spike;
   logic [3:0]  fifo_cnt;
   logic        ovf;
   logic [15:0] ts;

   adex_spike_event_encoder_if bus ();

   adex_spike_event_encoder #(
      .TS_W       (TS_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .clear_i    (clr),
      .tick_i     (tick),
      .spike_i    (spike),
      .out        (bus.master),
      .fifo_cnt_o (fifo_cnt),
      .overflow_o (ovf),
      .ts_o       (ts)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int unsigned mq[$];
   bit          m_busy;
   int unsigned m_cur;
   int          m_bidx;
   int unsigned m_ts;
   int unsigned m_isi;
   bit          m_ovf;

   logic [8:0]  lg[$];
   bit          do_chk = 1'b1;
   bit          hold;
   logic [7:0]  p_data;
   logic        p_last;
   int          cyc = 0;
   int          first_v;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_busy = 0;
      m_cur  = 0;
      m_bidx = 0;
      m_ts   = 0;
      m_isi  = 0;
      m_ovf  = 0;
      hold   = 0;
   endtask

   task automatic step(input bit e, input bit c, input bit t,
                       input bit s, input bit r);
      int unsigned cap;
      int          pre_n;
      en = e; clr = c; tick = t; spike = s;
      bus.out_ready_i = r;
      #1;
      if (do_chk) begin
         chk("valid", 32'(bus.out_valid_o), 32'(m_busy));
         if (m_busy) begin
            chk("data", 32'(bus.out_data_o),
                (m_cur >> (8 * (NB - 1 - m_bidx))) & 32'hFF);
            chk("last", 32'(bus.out_last_o),
                32'(m_bidx == NB - 1));
         end else begin
            chk("last_idle", 32'(bus.out_last_o), 0);
         end
         chk("fifo_cnt", 32'(fifo_cnt), mq.size());
         chk("overflow", 32'(ovf), 32'(m_ovf));
         chk("ts", 32'(ts), m_ts);
         if (hold) begin
            chk("hold_data", 32'(bus.out_data_o), 32'(p_data));
            chk("hold_last", 32'(bus.out_last_o), 32'(p_last));
         end
      end
      if (bus.out_valid_o && first_v < 0) first_v = cyc;
      hold   = bus.out_valid_o & !r & !c;
      p_data = bus.out_data_o;
      p_last = bus.out_last_o;
      if (bus.out_valid_o && r && !c)
         lg.push_back({bus.out_last_o, bus.out_data_o});
`ifdef ADEX_EVT_ISI_EN
      cap = m_isi;
`else
      cap = m_ts;
`endif
      if (c) begin
         m_reset();
      end else begin
         pre_n = mq.size();
         if (!m_busy) begin
            if (pre_n > 0) begin
               m_cur = mq.pop_front(); m_busy = 1; m_bidx = 0;
            end
         end else if (r) begin
            if (m_bidx < NB - 1) m_bidx++;
            else if (pre_n > 0) begin
               m_cur = mq.pop_front(); m_bidx = 0;
            end else m_busy = 0;
         end
         if (e && s) begin
            if (pre_n < DEPTH) mq.push_back(cap);
            else m_ovf = 1;
            m_isi = (e && t) ? 1 : 0;
         end else if (e && t && m_isi < 32'hFFFF) begin
            m_isi++;
         end
         if (e && t) m_ts = (m_ts + 1) & 32'hFFFF;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((m_busy || mq.size() > 0) && n < 300) begin
         step(1, 0, 0, 0, 1);
         n++;
      end
      chk("drain_timeout", 32'(n < 300), 1);
      step(1, 0, 0, 0, 1);
   endtask

   function automatic logic [31:0] ev(input int k);
      return {16'h0, lg[2*k][7:0], lg[2*k+1][7:0]};
   endfunction

   task automatic chk_ev(input int k, input logic [31:0] exp);
      if (lg.size() >= 2 * k + 2) begin
         chk("ev_val", ev(k), exp);
         chk("ev_first_last", 32'(lg[2*k][8]), 0);
         chk("ev_last", 32'(lg[2*k+1][8]), 1);
      end else begin
         chk("ev_missing", lg.size(), 2 * k + 2);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 0; clr = 0; tick = 0; spike = 0;
      bus.out_ready_i = 1'b0;
      m_reset();
      first_v = -1;
      #2;
      chk("rst_valid", 32'(bus.out_valid_o), 0);
      chk("rst_data", 32'(bus.out_data_o), 0);
      chk("rst_last", 32'(bus.out_last_o), 0);
      chk("rst_cnt", 32'(fifo_cnt), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_ts", 32'(ts), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: five ticks then one spike
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1);
      lg.delete();
      first_v = -1;
      begin
         int sc;
         sc = cyc;
         step(1, 0, 0, 1, 1);
         for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
         chk("t1_latency", first_v - sc, 2);
      end
      chk("t1_nbytes", lg.size(), 2);
      chk_ev(0, 32'h0005);

      // 2: fill and overflow with the reader stalled
      step(1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      lg.delete();
      for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 0);
      chk("t2_cnt", 32'(fifo_cnt), 8);
      chk("t2_ovf", 32'(ovf), 1);
      drain();
      chk("t2_nbytes", lg.size(), 18);
      for (int k = 0; k < 9; k++) begin
`ifdef ADEX_EVT_ISI_EN
         chk_ev(k, 32'h1);
`else
         chk_ev(k, 32'(k + 1));
`endif
      end
      chk("t2_idle", 32'(bus.out_valid_o), 0);

      // 3: toggling ready mid-event
      lg.delete();
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, i[0]);
      drain();
      chk("t3_nbytes", lg.size(), 6);

`ifndef ADEX_EVT_ISI_EN
      // 4: timestamp wrap
      step(1, 1, 0, 0, 1);
      do_chk = 0;
      for (int i = 0; i < 65535; i++) step(1, 0, 1, 0, 1);
      do_chk = 1;
      chk("t4_ts_max", 32'(ts), 32'hFFFF);
      lg.delete();
      step(1, 0, 1, 1, 1);
      chk("t4_ts_wrap", 32'(ts), 0);
      drain();
      chk_ev(0, 32'hFFFF);
`endif

      // 5: clear after the first byte
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 0);
      chk("t5_ovf_set", 32'(ovf), 1);
      step(1, 0, 0, 0, 1);
      chk("t5_mid", 32'(bus.out_valid_o), 1);
      step(1, 1, 0, 0, 0);
      chk("t5_valid", 32'(bus.out_valid_o), 0);
      chk("t5_cnt", 32'(fifo_cnt), 0);
      chk("t5_ovf", 32'(ovf), 0);
      chk("t5_ts", 32'(ts), 0);

`ifdef ADEX_EVT_ISI_EN
      // 6: interval payloads and saturation
      lg.delete();
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1);
      step(1, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 1);
      step(1, 0, 0, 1, 1);
      drain();
      chk_ev(0, 32'h0003);
      chk_ev(1, 32'h0007);
      lg.delete();
      do_chk = 0;
      for (int i = 0; i < 70000; i++) step(1, 0, 1, 0, 1);
      do_chk = 1;
      step(1, 0, 0, 1, 1);
      drain();
      chk_ev(0, 32'hFFFF);
`endif

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 7) != 0,
              $urandom_range(0, 63) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
